sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single-word SDRAM controller port between three masters: the audio FIFO refill
//  (I2S streamer), the graphics frame reader and the SD-card loader (writer). Each master sees
//  its own wait/ack pair, the same protocol it sees from the controller directly. Audio has fixed
//  top priority; graphics and loader alternate round-robin. A hold limit stops long bursts
//  from starving audio.
// PARAMETERS
//  ADDR_W    25   SDRAM word address width
//  DATA_W    16   SDRAM data width
//  MAX_HOLD  256  cycles a non-audio owner may hold the port while audio is waiting
// PORTS
//  Clk50       in   1       system clock; all logic on posedge
//  reset       in   1       synchronous, active-high
//  m_req[2:0]  in   3       level request/lock per master (0=audio,1=gfx,2=loader); held high for whole burst
//  m_rd[2:0]   in   3       per-master read strobe, held until its m_ac
//  m_wr[2:0]   in   3       per-master write strobe, held until its m_ac
//  m_addr0/1/2 in   ADDR_W  per-master word address
//  m_wdata2    in   DATA_W  loader write data (only master 2 writes)
//  m_wait[2:0] out  3       per-master wait: 1 = not owner or controller busy
//  m_ac[2:0]   out  3       per-master ack, controller ack routed to owner only
//  m_rdata     out  DATA_W  controller read data, broadcast
//  ctl_rd      out  1       read strobe to controller
//  ctl_wr      out  1       write strobe to controller
//  ctl_addr    out  ADDR_W  address to controller
//  ctl_wdata   out  DATA_W  write data to controller
//  ctl_wait    in   1       controller cannot accept a command
//  ctl_ac      in   1       controller ack: read data valid / write taken
//  ctl_rdata   in   DATA_W  controller read data
//  owner       out  2       current owner: 0..2, 3 = none
//  starve_cnt  out  8       saturating count of forced preemptions
// BEHAVIOUR
//  - Reset: owner=3, m_wait=3'b111, m_ac=0, ctl_rd=ctl_wr=0, ctl_addr=0, ctl_wdata=0,
//    hold_cnt=0, rr_ptr=gfx, starve_cnt=0. Reset mid-transfer drops ctl_rd/wr on the next cycle.
//  - FSM states: IDLE, OWN, GAP.
//    IDLE: if any m_req and !ctl_wait, register owner = audio if m_req[0], else the rr_ptr
//          master if it requests, else the other one; go to OWN.
//          Grant latency: m_req high in cycle N -> m_wait[i] low in cycle N+1.
//    OWN: ctl_rd/ctl_wr/ctl_addr/ctl_wdata = owner's signals (combinational mux on registered owner);
//         m_wait[owner] = ctl_wait; m_ac[owner] = ctl_ac; all other m_wait=1, m_ac=0.
//         Owner drops m_req -> owner=3, go to GAP; rr_ptr toggles if owner was gfx/loader.
//    GAP: one dead cycle with all m_wait=1, then IDLE. Back-to-back grants are 2 cycles apart.
//  - hold_cnt: clears on each grant, counts up in OWN while owner!=audio and m_req[0]=1,
//    saturates at MAX_HOLD.
//  - Preemption: hold_cnt==MAX_HOLD and owner's rd/wr both low (word boundary, nothing
//    in flight) -> owner goes directly to audio, skipping GAP; starve_cnt++ (saturates at 255);
//    rr_ptr is not toggled. The preempted master sees m_wait=1, keeps m_req high, and
//    resumes after audio releases.
//  - No preemption while ctl_rd or ctl_wr is asserted. An ack is never lost or misrouted.
//  - m_rd/m_wr from non-owners are ignored. Owner asserting rd and wr together is illegal;
//    ctl_wr is suppressed.
//  - m_req dropped while that master's strobe is still high: the grant is released anyway
//    (master error).
//  - m_rdata = ctl_rdata at all times.
// TESTING
//  1) Reset, m_req=3'b001, ctl_wait=0 -> cycle+1 owner=0, m_wait=3'b110; m_rd[0] + ctl_ac -> m_ac=3'b001.
//  2) m_req=3'b110 together from IDLE, rr_ptr=gfx -> owner=1; gfx releases -> GAP, owner=2
//     two cycles after release.
//  3) Loader owns and bursts, audio m_req[0]=1 -> after 256 cycles at first idle word boundary
//     owner=0, starve_cnt=1, loader m_wait[2]=1.
//  4) Gfx rd outstanding at hold limit with ctl_ac delayed 5 cycles -> no switch until
//     ack is routed to m_ac[1] and rd drops.
//  5) ctl_wait=1 in IDLE with m_req=3'b001 -> no grant until ctl_wait=0; grant the next cycle.
//  6) reset asserted in OWN with ctl_rd=1 -> next cycle ctl_rd=0, owner=3, m_wait=3'b111.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//   Bundles the three-master request side and the single controller side of
//   the SDRAM port arbiter.
//   master modport : the environment (audio/gfx/loader masters and the SDRAM
//                    controller) - drives requests, strobes, addresses, write
//                    data and the controller's wait/ack/read data.
//   slave modport  : the arbiter - drives per-master wait/ack, broadcast read
//                    data and the muxed command towards the controller.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    // master side (index 0 = audio, 1 = gfx, 2 = loader)
    logic [2:0]        m_req;
    logic [2:0]        m_rd;
    logic [2:0]        m_wr;
    logic [ADDR_W-1:0] m_addr0;
    logic [ADDR_W-1:0] m_addr1;
    logic [ADDR_W-1:0] m_addr2;
    logic [DATA_W-1:0] m_wdata2;
    logic [2:0]        m_wait;
    logic [2:0]        m_ac;
    logic [DATA_W-1:0] m_rdata;

    // controller side
    logic              ctl_rd;
    logic              ctl_wr;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_wdata;
    logic              ctl_wait;
    logic              ctl_ac;
    logic [DATA_W-1:0] ctl_rdata;

    modport master (
        output m_req, m_rd, m_wr, m_addr0, m_addr1, m_addr2, m_wdata2,
        input  m_wait, m_ac, m_rdata,
        input  ctl_rd, ctl_wr, ctl_addr, ctl_wdata,
        output ctl_wait, ctl_ac, ctl_rdata
    );

    modport slave (
        input  m_req, m_rd, m_wr, m_addr0, m_addr1, m_addr2, m_wdata2,
        output m_wait, m_ac, m_rdata,
        output ctl_rd, ctl_wr, ctl_addr, ctl_wdata,
        input  ctl_wait, ctl_ac, ctl_rdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single-word SDRAM controller port between the audio FIFO
//   refill (master 0, fixed top priority), the graphics frame reader
//   (master 1) and the SD-card loader (master 2). Gfx and loader alternate
//   round-robin. A non-audio owner that keeps audio waiting for MAX_HOLD
//   cycles is preempted at its next idle word boundary.
// Ports
//   Clk50      : system clock, posedge
//   reset      : synchronous, active-high
//   bus        : sdram_port_arbiter_if.slave - master requests/strobes and
//                per-master wait/ack, plus the command port to the controller
//   owner      : current owner 0..2, 3 = none
//   starve_cnt : saturating count of forced preemptions
module sdram_port_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 256
) (
    input  logic                 Clk50,
    input  logic                 reset,
    sdram_port_arbiter_if.slave  bus,
    output logic [1:0]           owner,
    output logic [7:0]           starve_cnt
);
    localparam int          HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [1:0]  NO_OWNER  = 2'd3;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rr_loader;   // 0: gfx favoured next, 1: loader favoured next

    logic [2:0]        own_sel;
    logic              own_req;
    logic              own_rd;
    logic              own_wr;
    logic              rr_hit;
    logic [1:0]        rr_master;
    logic [1:0]        rr_other;
    logic              preempt;

    // owner is NO_OWNER outside OWN, so own_sel is all-zero in IDLE/GAP and
    // every master then sees wait=1 and no ack.
    always_comb begin
        own_sel   = 3'b000;
        own_sel[0] = (owner == 2'd0);
        own_sel[1] = (owner == 2'd1);
        own_sel[2] = (owner == 2'd2);

        own_req   = |(own_sel & bus.m_req);
        own_rd    = |(own_sel & bus.m_rd);
        own_wr    = |(own_sel & bus.m_wr);

        rr_master = rr_loader ? 2'd2 : 2'd1;
        rr_other  = rr_loader ? 2'd1 : 2'd2;
        rr_hit    = rr_loader ? bus.m_req[2] : bus.m_req[1];

        // Only at a word boundary: the owner's strobes are both low, so no
        // command is in flight and no ack can be misrouted.
        preempt   = (owner != 2'd0) && bus.m_req[0] && (hold_cnt == HOLD_LIMIT)
                    && !own_rd && !own_wr;
    end

    always_comb begin
        bus.m_wait    = ~own_sel | {3{bus.ctl_wait}};
        bus.m_ac      = own_sel & {3{bus.ctl_ac}};
        bus.m_rdata   = bus.ctl_rdata;
        bus.ctl_rd    = own_rd;
        // rd together with wr is illegal; the write is dropped
        bus.ctl_wr    = own_wr & ~own_rd;
        bus.ctl_addr  = '0;
        if (own_sel[0]) begin
            bus.ctl_addr = bus.m_addr0;
        end else if (own_sel[1]) begin
            bus.ctl_addr = bus.m_addr1;
        end else if (own_sel[2]) begin
            bus.ctl_addr = bus.m_addr2;
        end
        bus.ctl_wdata = own_sel[2] ? bus.m_wdata2 : '0;
    end

    always_ff @(posedge Clk50) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= NO_OWNER;
            hold_cnt   <= '0;
            rr_loader  <= 1'b0;
            starve_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if ((|bus.m_req) && !bus.ctl_wait) begin
                        state    <= OWN;
                        hold_cnt <= '0;
                        if (bus.m_req[0]) begin
                            owner <= 2'd0;
                        end else if (rr_hit) begin
                            owner <= rr_master;
                        end else begin
                            owner <= rr_other;
                        end
                    end
                end
                OWN: begin
                    if (!own_req) begin
                        // released (even with a strobe still up)
                        state <= GAP;
                        owner <= NO_OWNER;
                        if (owner != 2'd0) begin
                            rr_loader <= ~rr_loader;
                        end
                    end else if (preempt) begin
                        // hand straight to audio; round-robin order untouched
                        owner    <= 2'd0;
                        hold_cnt <= '0;
                        if (starve_cnt != 8'hFF) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end else if ((owner != 2'd0) && bus.m_req[0] && (hold_cnt != HOLD_LIMIT)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    owner <= NO_OWNER;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 16;
    localparam int MAX_HOLD = 256;

    logic       Clk50 = 1'b0;
    logic       reset;
    logic [1:0] owner;
    logic [7:0] starve_cnt;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk50      (Clk50),
        .reset      (reset),
        .bus        (bus.slave),
        .owner      (owner),
        .starve_cnt (starve_cnt)
    );

    always #10 Clk50 = ~Clk50;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: who owns the port and the counters around it
    int  mo_owner;      // 0..2, 3 = nobody
    bit  mo_gap;        // in the dead cycle after a release
    int  mo_hold;       // cycles audio has waited on a non-audio owner
    int  mo_rr;         // 1 = gfx favoured next, 2 = loader favoured next
    int  mo_starve;
    bit  mo_valid = 0;

    // stimulus bookkeeping
    logic [2:0] last_m_ac;
    bit         last_take;
    int         ac_cnt;
    int         words [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [2:0]        ew;
        logic [2:0]        ea;
        logic              erd;
        logic              ewr;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd;
        ew = 3'b111; ea = 3'b000; erd = 1'b0; ewr = 1'b0; eaddr = '0; ewd = '0;
        if (mo_owner < 3) begin
            ew[mo_owner] = bus.ctl_wait;
            ea[mo_owner] = bus.ctl_ac;
            erd = bus.m_rd[mo_owner];
            ewr = bus.m_wr[mo_owner] & ~bus.m_rd[mo_owner];
            eaddr = (mo_owner == 0) ? bus.m_addr0 : (mo_owner == 1) ? bus.m_addr1 : bus.m_addr2;
            if (mo_owner == 2) ewd = bus.m_wdata2;
        end
        chk("owner", 64'(owner), 64'(mo_owner));
        chk("starve_cnt", 64'(starve_cnt), 64'(mo_starve));
        chk("m_wait", 64'(bus.m_wait), 64'(ew));
        chk("m_ac", 64'(bus.m_ac), 64'(ea));
        chk("ctl_rd", 64'(bus.ctl_rd), 64'(erd));
        chk("ctl_wr", 64'(bus.ctl_wr), 64'(ewr));
        chk("ctl_addr", 64'(bus.ctl_addr), 64'(eaddr));
        chk("ctl_wdata", 64'(bus.ctl_wdata), 64'(ewd));
        chk("m_rdata", 64'(bus.m_rdata), 64'(bus.ctl_rdata));
    endtask

    task automatic model_step();
        if (reset) begin
            mo_owner = 3; mo_gap = 0; mo_hold = 0; mo_rr = 1; mo_starve = 0; mo_valid = 1;
        end else if (mo_valid) begin
            if (mo_gap) begin
                mo_gap = 0;
            end else if (mo_owner == 3) begin
                if (bus.m_req != 3'b000 && !bus.ctl_wait) begin
                    if (bus.m_req[0]) mo_owner = 0;
                    else if (bus.m_req[mo_rr]) mo_owner = mo_rr;
                    else mo_owner = 3 - mo_rr;
                    mo_hold = 0;
                end
            end else if (!bus.m_req[mo_owner]) begin
                if (mo_owner != 0) mo_rr = 3 - mo_rr;
                mo_owner = 3;
                mo_gap = 1;
            end else if (mo_owner != 0 && bus.m_req[0]) begin
                if (mo_hold >= MAX_HOLD && !bus.m_rd[mo_owner] && !bus.m_wr[mo_owner]) begin
                    mo_owner = 0;
                    mo_hold = 0;
                    mo_starve = (mo_starve < 255) ? mo_starve + 1 : 255;
                end else if (mo_hold < MAX_HOLD) begin
                    mo_hold++;
                end
            end
        end
    endtask

    // one clock: compare at the falling edge, advance the model, then return
    // just after the rising edge so the caller can drive the next inputs
    task automatic cycle();
        @(negedge Clk50);
        if (mo_valid) model_check();
        last_m_ac = bus.m_ac;
        last_take = (bus.ctl_rd || bus.ctl_wr) && !bus.ctl_wait && !bus.ctl_ac && (ac_cnt == 0);
        model_step();
        @(posedge Clk50);
        #1;
    endtask

    task automatic random_drive();
        if (last_take) ac_cnt = $urandom_range(1, 5);
        if (ac_cnt > 0) begin
            ac_cnt--;
            bus.ctl_ac = (ac_cnt == 0);
        end else begin
            bus.ctl_ac = ($urandom_range(0, 63) == 0);   // stray ack: must only reach the owner
        end
        bus.ctl_wait  = ($urandom_range(0, 3) == 0);
        bus.ctl_rdata = DATA_W'($urandom);
        for (int i = 0; i < 3; i++) begin
            if (!bus.m_req[i]) begin
                if ($urandom_range(0, (i == 0) ? 40 : 12) == 0) begin
                    bus.m_req[i] = 1'b1;
                    words[i] = (i == 2) ? $urandom_range(20, 120) : $urandom_range(1, 8);
                end
            end else if (bus.m_rd[i] || bus.m_wr[i]) begin
                if (last_m_ac[i]) begin
                    bus.m_rd[i] = 1'b0;
                    bus.m_wr[i] = 1'b0;
                    words[i]--;
                end
            end else if (words[i] <= 0) begin
                bus.m_req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                if (i == 2 && $urandom_range(0, 1) == 1) bus.m_wr[i] = 1'b1;
                else bus.m_rd[i] = 1'b1;
                case (i)
                    0: bus.m_addr0 = ADDR_W'($urandom);
                    1: bus.m_addr1 = ADDR_W'($urandom);
                    default: bus.m_addr2 = ADDR_W'($urandom);
                endcase
                bus.m_wdata2 = DATA_W'($urandom);
            end
        end
    endtask

    initial begin
        int  took;
        bit  done;
        reset = 1'b1;
        bus.m_req = '0; bus.m_rd = '0; bus.m_wr = '0;
        bus.m_addr0 = '0; bus.m_addr1 = '0; bus.m_addr2 = '0; bus.m_wdata2 = '0;
        bus.ctl_wait = 1'b0; bus.ctl_ac = 1'b0; bus.ctl_rdata = '0;
        ac_cnt = 0; last_take = 0; last_m_ac = '0;
        for (int i = 0; i < 3; i++) words[i] = 0;
        @(posedge Clk50); #1;
        cycle();

        // reset state
        chk("rst_owner", 64'(owner), 64'd3);
        chk("rst_m_wait", 64'(bus.m_wait), 64'h7);
        chk("rst_m_ac", 64'(bus.m_ac), 64'h0);
        chk("rst_ctl_rdwr", 64'({bus.ctl_rd, bus.ctl_wr}), 64'h0);
        chk("rst_ctl_addr", 64'(bus.ctl_addr), 64'h0);
        chk("rst_starve", 64'(starve_cnt), 64'h0);
        chk("model_rst_rr", 64'(mo_rr), 64'd1);

        // audio grant one cycle after request; ack routed to audio; rd+wr drops wr
        reset = 1'b0;
        bus.m_req = 3'b001; bus.m_addr0 = 25'h123;
        cycle();
        chk("t1_owner", 64'(owner), 64'd0);
        chk("t1_m_wait", 64'(bus.m_wait), 64'b110);
        bus.m_rd[0] = 1'b1; bus.m_wr[0] = 1'b1; bus.ctl_ac = 1'b1;
        #1;
        chk("t1_m_ac", 64'(bus.m_ac), 64'b001);
        chk("t1_ctl_wr_sup", 64'({bus.ctl_rd, bus.ctl_wr}), 64'b10);
        chk("t1_ctl_addr", 64'(bus.ctl_addr), 64'h123);
        cycle();
        bus.m_rd = '0; bus.m_wr = '0; bus.ctl_ac = 1'b0; bus.m_req = '0;
        cycle();
        chk("t1_release", 64'(owner), 64'd3);
        cycle();

        // controller busy blocks the grant
        bus.ctl_wait = 1'b1; bus.m_req = 3'b001;
        for (int k = 0; k < 3; k++) cycle();
        chk("t5_blocked", 64'(owner), 64'd3);
        bus.ctl_wait = 1'b0;
        cycle();
        chk("t5_grant", 64'(owner), 64'd0);
        chk("t5_m_wait", 64'(bus.m_wait), 64'b110);
        bus.m_req = '0;
        cycle(); cycle();

        // gfx and loader together: gfx first, loader after the gap
        bus.m_req = 3'b110;
        cycle();
        chk("t2_gfx_first", 64'(owner), 64'd1);
        bus.m_req = 3'b100;
        cycle();
        chk("t2_gap_owner", 64'(owner), 64'd3);
        chk("t2_gap_wait", 64'(bus.m_wait), 64'h7);
        cycle();
        chk("t2_idle_owner", 64'(owner), 64'd3);
        cycle();
        chk("t2_loader", 64'(owner), 64'd2);
        chk("model_t2_rr", 64'(mo_rr), 64'd2);

        // loader bursts while audio waits: preempted at first idle word after the limit
        bus.m_req = 3'b101;
        done = 0; took = -1;
        for (int k = 0; k < 400 && !done; k++) begin
            case (k % 3)
                0: begin bus.m_wr[2] = 1'b1; bus.ctl_ac = 1'b0; end
                1: bus.ctl_ac = 1'b1;
                default: begin bus.m_wr[2] = 1'b0; bus.ctl_ac = 1'b0; end
            endcase
            bus.m_addr2 = ADDR_W'(k); bus.m_wdata2 = DATA_W'(k * 3);
            cycle();
            if (owner == 2'd0) begin done = 1; took = k; end
        end
        bus.m_wr = '0; bus.ctl_ac = 1'b0;
        chk("t3_preempt_cycle", 64'(took), 64'd257);
        chk("t3_starve", 64'(starve_cnt), 64'd1);
        chk("t3_loader_wait", 64'(bus.m_wait[2]), 64'd1);
        bus.m_req = 3'b100;
        cycle(); cycle(); cycle();
        chk("t3_loader_resume", 64'(owner), 64'd2);
        bus.m_req = '0;
        cycle(); cycle();

        // gfx read outstanding at the limit: no switch until ack and rd drop
        bus.m_req = 3'b010;
        cycle();
        chk("t4_gfx", 64'(owner), 64'd1);
        bus.m_req = 3'b011;
        for (int k = 0; k < 250; k++) cycle();
        bus.m_rd[1] = 1'b1; bus.m_addr1 = 25'h1ABCD;
        for (int k = 0; k < 20; k++) cycle();
        chk("t4_held", 64'(owner), 64'd1);
        chk("t4_ctl_rd", 64'(bus.ctl_rd), 64'd1);
        bus.ctl_ac = 1'b1;
        #1;
        chk("t4_ack_route", 64'(bus.m_ac), 64'b010);
        cycle();
        chk("t4_no_switch_on_ack", 64'(owner), 64'd1);
        bus.m_rd[1] = 1'b0; bus.ctl_ac = 1'b0;
        cycle();
        chk("t4_audio", 64'(owner), 64'd0);
        chk("t4_starve", 64'(starve_cnt), 64'd2);
        bus.m_req = 3'b010;
        cycle(); cycle(); cycle();
        chk("t4_gfx_resume", 64'(owner), 64'd1);
        bus.m_req = '0;
        cycle(); cycle();

        // reset in the middle of a read
        bus.m_req = 3'b100;
        cycle();
        bus.m_rd[2] = 1'b1;
        #1;
        chk("t6_ctl_rd_before", 64'(bus.ctl_rd), 64'd1);
        reset = 1'b1;
        cycle();
        chk("t6_ctl_rd", 64'(bus.ctl_rd), 64'd0);
        chk("t6_owner", 64'(owner), 64'd3);
        chk("t6_m_wait", 64'(bus.m_wait), 64'h7);
        chk("t6_starve", 64'(starve_cnt), 64'd0);
        reset = 1'b0; bus.m_req = '0; bus.m_rd = '0;
        cycle();

        // randomized traffic against the model
        for (int k = 0; k < 20000; k++) begin
            random_drive();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
